// File: rtl/sic_pkg.sv
// Shared types for the SIC dispatch path: packet layout, per-SIC port bundles
// and the wrap-around issue-id age compare.
package sic_pkg;

    localparam int SIC_ID_WIDTH     = 4;
    localparam int SIC_NUM_PHY_REGS = 32;
    localparam int SIC_PREG_W       = $clog2(SIC_NUM_PHY_REGS);

    typedef struct packed {
        logic [3:0]            op;
        logic [SIC_PREG_W-1:0] rd;
        logic [SIC_PREG_W-1:0] rs1;
        logic [SIC_PREG_W-1:0] rs2;
        logic [15:0]           imm;
    } sic_info_t;

    typedef struct packed {
        logic                    valid;
        logic [31:0]             pc;
        logic [SIC_ID_WIDTH-1:0] issue_id;
        sic_info_t               info;
    } sic_packet_t;

    typedef struct packed {
        sic_packet_t pkt;
    } sic_sub_in;

    typedef struct packed {
        logic                    req_instr;
        logic                    redir_valid;
        logic [31:0]             redir_pc;
        logic [SIC_ID_WIDTH-1:0] redir_id;
    } sic_sub_out;

    // a is older than b when (a - b) mod 2^w has its MSB set; ids are zero-extended.
    function automatic logic id_older(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [31:0] d;
        d = a - b;
        return d[w-1];
    endfunction

endpackage

// File: rtl/sic_pkt_fifo.sv
// Parameterised synchronous FIFO with a synchronous clear that wins over push/pop.
module sic_pkt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sic_dispatcher.sv
// Buffers issue-stage packets and hands them round-robin to requesting SICs;
// arbitrates SIC redirects (oldest id wins) and flushes buffered work on redirect.
module sic_dispatcher
    import sic_pkg::*;
#(
    parameter int NUM_SIC      = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int NUM_PHY_REGS = 32,
    parameter int ID_WIDTH     = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  sic_packet_t                        in_pkt,
    input  logic [NUM_SIC-1:0]                 sic_req_instr,
    output sic_packet_t [NUM_SIC-1:0]          sic_pkt,
    input  logic [NUM_SIC-1:0]                 sic_redir_valid,
    input  logic [NUM_SIC-1:0][31:0]           sic_redir_pc,
    input  logic [NUM_SIC-1:0][ID_WIDTH-1:0]   sic_redir_id,
    output logic                               redirect_valid,
    output logic [31:0]                        redirect_pc,
    output logic [ID_WIDTH-1:0]                redirect_issue_id
);

    localparam int RR_W  = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (NUM_PHY_REGS != SIC_NUM_PHY_REGS || ID_WIDTH > SIC_ID_WIDTH) begin : g_param_check
        $error("sic_dispatcher parameters do not match the sic_packet_t layout");
    end

    logic              flush;
    logic              push;
    logic              load;
    logic              accept;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    sic_packet_t       fifo_head;

    logic              offer_vld;
    sic_packet_t       offer_pkt;
    logic [RR_W-1:0]   offer_tgt;
    logic [RR_W-1:0]   rr_ptr;
    logic [RR_W-1:0]   rr_sel;
    logic              rr_found;

    logic [RR_W-1:0]   win_idx;
    logic              win_found;

    assign flush    = |sic_redir_valid;
    assign in_ready = !fifo_full && !flush;
    assign push     = in_valid && in_ready;
    assign load     = !offer_vld && !fifo_empty && rr_found && !flush;
    assign accept   = offer_vld && !sic_req_instr[offer_tgt];

    sic_pkt_fifo #(
        .WIDTH ($bits(sic_packet_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .din   (in_pkt),
        .pop   (load),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // First requester strictly after rr_ptr, wrapping round to rr_ptr itself.
    always_comb begin
        int idx;
        idx      = 0;
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= NUM_SIC; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_SIC;
            if (!rr_found && sic_req_instr[idx]) begin
                rr_found = 1'b1;
                rr_sel   = RR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offer_vld <= 1'b0;
            offer_pkt <= '0;
            offer_tgt <= '0;
            rr_ptr    <= RR_W'(NUM_SIC - 1);
        end else if (flush) begin
            offer_vld <= 1'b0;
        end else if (load) begin
            offer_vld <= 1'b1;
            offer_pkt <= fifo_head;
            offer_tgt <= rr_sel;
            rr_ptr    <= rr_sel;
        end else if (accept) begin
            offer_vld <= 1'b0;
        end
    end

    always_comb begin
        sic_pkt = '0;
        if (offer_vld) begin
            sic_pkt[offer_tgt]       = offer_pkt;
            sic_pkt[offer_tgt].valid = 1'b1;
        end
    end

    // Strictly-older replaces the current winner, so equal ids keep the lowest index.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NUM_SIC; k++) begin
            if (sic_redir_valid[k] &&
                (!win_found || id_older(32'(sic_redir_id[k]), 32'(sic_redir_id[win_idx]), ID_WIDTH))) begin
                win_found = 1'b1;
                win_idx   = RR_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
            redirect_issue_id <= '0;
        end else begin
            redirect_valid <= flush;
            if (flush) begin
                redirect_pc       <= sic_redir_pc[win_idx];
                redirect_issue_id <= sic_redir_id[win_idx];
            end
        end
    end

endmodule

// File: tb/tb_sic_dispatcher.sv
// Scenario bench for sic_dispatcher: expected deliveries are queued as packets
// are driven and matched by a monitor whenever a SIC takes its offer.
module tb_sic_dispatcher;
    import sic_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    sic_packet_t          in_pkt;
    logic [1:0]           sic_req_instr;
    sic_packet_t [1:0]    sic_pkt;
    logic [1:0]           sic_redir_valid;
    logic [1:0][31:0]     sic_redir_pc;
    logic [1:0][3:0]      sic_redir_id;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic [3:0]           redirect_issue_id;

    typedef struct {
        int          tgt;
        sic_packet_t pkt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    sic_dispatcher #(
        .NUM_SIC(2), .FIFO_DEPTH(4), .NUM_PHY_REGS(32), .ID_WIDTH(4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_pkt            (in_pkt),
        .sic_req_instr     (sic_req_instr),
        .sic_pkt           (sic_pkt),
        .sic_redir_valid   (sic_redir_valid),
        .sic_redir_pc      (sic_redir_pc),
        .sic_redir_id      (sic_redir_id),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .redirect_issue_id (redirect_issue_id)
    );

    always #5 clk = ~clk;

    function automatic sic_packet_t mk_pkt(input logic [3:0] id);
        sic_packet_t p;
        p           = '0;
        p.valid     = 1'b1;
        p.pc        = 32'h0040_0000 + 32'(id) * 4;
        p.issue_id  = id;
        p.info.op   = ~id;
        p.info.rd   = {1'b0, id};
        p.info.imm  = 16'hA000 | 16'(id);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] id, input int tgt, input bit expect_it);
        exp_t e;
        in_valid = 1'b1;
        in_pkt   = mk_pkt(id);
        if (expect_it) begin
            e.tgt = tgt;
            e.pkt = mk_pkt(id);
            sb.push_back(e);
        end
    endtask

    // A delivery is any cycle in which a SIC sees a valid offer with its request low.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (sic_pkt[k].valid && !sic_req_instr[k]) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL deliver: got id %0d on sic%0d, required no delivery",
                                 sic_pkt[k].issue_id, k);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.tgt != k || sic_pkt[k] !== mon_e.pkt)
                            $display("FAIL deliver: got sic%0d pkt %h, required sic%0d pkt %h",
                                     k, sic_pkt[k], mon_e.tgt, mon_e.pkt);
                        else
                            n_pass++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_pkt = '0; sic_req_instr = 2'b00;
        sic_redir_valid = '0; sic_redir_pc = '0; sic_redir_id = '0;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b required 1", in_ready); else n_pass++;
        n_checks++; if (sic_pkt !== '0) $display("FAIL rst_sic_pkt: got %h required 0", sic_pkt); else n_pass++;
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL rst_redir_valid: got %b required 0", redirect_valid); else n_pass++;
        n_checks++; if (redirect_pc !== 32'h0) $display("FAIL rst_redir_pc: got %h required 0", redirect_pc); else n_pass++;
        n_checks++; if (redirect_issue_id !== 4'h0) $display("FAIL rst_redir_id: got %h required 0", redirect_issue_id); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_dispatch();
        sic_req_instr = 2'b11;
        send(4'd1, 0, 1'b1);
        tick();                                   // push id1
        send(4'd2, 1, 1'b1);
        tick();                                   // load id1 -> SIC0, push id2
        in_valid = 1'b0;
        n_checks++;
        if (!(sic_pkt[0].valid && sic_pkt[0].issue_id == 4'd1 && sic_pkt[0].pc == 32'h0040_0004))
            $display("FAIL single_offer: got sic0 %h required id1 valid", sic_pkt[0]);
        else n_pass++;
        sic_req_instr = 2'b10;                    // SIC0 latches it this cycle
        tick();
        n_checks++; if (sic_pkt !== '0) $display("FAIL single_no_reload: got %h required 0", sic_pkt); else n_pass++;
        tick();                                   // id2 -> SIC1
        n_checks++;
        if (!(sic_pkt[1].valid && sic_pkt[1].issue_id == 4'd2) || sic_pkt[0] !== '0)
            $display("FAIL single_second: got %h required id2 on sic1", sic_pkt);
        else n_pass++;
        sic_req_instr = 2'b00;
        tick();
        sic_req_instr = 2'b11;
    endtask

    task automatic test_round_robin_idle();
        send(4'd1, 0, 1'b1);
        tick();
        send(4'd2, 1, 1'b1);
        tick();                                   // id1 -> SIC0
        send(4'd3, 0, 1'b1);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (!(sic_pkt[0].valid && sic_pkt[0].issue_id == 4'd1) || sic_pkt[1] !== '0)
            $display("FAIL rr_hold: got %h required id1 held on sic0", sic_pkt);
        else n_pass++;
        tick();
        sic_req_instr = 2'b10;                    // SIC0 finally accepts
        tick();
        tick();                                   // id2 -> SIC1
        n_checks++;
        if (!(sic_pkt[1].valid && sic_pkt[1].issue_id == 4'd2))
            $display("FAIL rr_sic1: got %h required id2 on sic1", sic_pkt);
        else n_pass++;
        sic_req_instr = 2'b00;
        tick();
        sic_req_instr = 2'b11;
        tick();                                   // id3 -> SIC0
        n_checks++;
        if (!(sic_pkt[0].valid && sic_pkt[0].issue_id == 4'd3))
            $display("FAIL rr_sic0_again: got %h required id3 on sic0", sic_pkt);
        else n_pass++;
        sic_req_instr = 2'b10;
        tick();
        sic_req_instr = 2'b00;
        tick();
    endtask

    task automatic drain_sic0(input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            sic_req_instr = 2'b01;
            while (!sic_pkt[0].valid && w < 10) begin
                tick();
                w++;
            end
            n_checks++;
            if (!sic_pkt[0].valid) $display("FAIL drain_timeout: got no offer on sic0 after %0d cycles, required one", w);
            else n_pass++;
            sic_req_instr = 2'b00;
            tick();
        end
    endtask

    task automatic test_full_fifo();
        sic_req_instr = 2'b00;
        for (int i = 0; i < 4; i++) begin
            send(4'(10 + i), 0, 1'b1);
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1) $display("FAIL full_ready_%0d: got %b required 1", i, in_ready); else n_pass++;
            tick();
        end
        send(4'd14, 0, 1'b1);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_not_ready: got %b required 0", in_ready); else n_pass++;
        tick();
        sic_req_instr = 2'b01;
        tick();                                   // pop id10 into offer
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL full_ready_again: got %b required 1", in_ready); else n_pass++;
        tick();                                   // id14 pushed
        in_valid = 1'b0;
        drain_sic0(5);
    endtask

    task automatic test_redirect_flush();
        sic_req_instr = 2'b00;
        for (int i = 0; i < 4; i++) begin
            send(4'(6 + i), 0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        sic_req_instr = 2'b01;
        tick();                                   // offer id6 on SIC0, 3 left buffered
        sic_redir_valid = 2'b10;
        sic_redir_pc[1] = 32'h0040_0100;
        sic_redir_id[1] = 4'd5;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b required 0", in_ready); else n_pass++;
        tick();
        sic_redir_valid = 2'b00;
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0100 || redirect_issue_id !== 4'd5)
            $display("FAIL flush_redirect: got v=%b pc=%h id=%0d required v=1 pc=00400100 id=5",
                     redirect_valid, redirect_pc, redirect_issue_id);
        else n_pass++;
        n_checks++; if (sic_pkt !== '0) $display("FAIL flush_offer: got %h required 0", sic_pkt); else n_pass++;
        tick();
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL flush_pulse: got %b required 0", redirect_valid); else n_pass++;
        tick(); tick();
        n_checks++; if (sic_pkt !== '0) $display("FAIL flush_fifo_empty: got %h required 0", sic_pkt); else n_pass++;
        sic_req_instr = 2'b00;
    endtask

    task automatic test_oldest_redirect();
        sic_redir_valid = 2'b11;
        sic_redir_id[0] = 4'd14; sic_redir_pc[0] = 32'h0050_0000;
        sic_redir_id[1] = 4'd1;  sic_redir_pc[1] = 32'h0060_0000;
        tick();
        n_checks++;
        if (redirect_pc !== 32'h0050_0000 || redirect_issue_id !== 4'd14)
            $display("FAIL wrap_sic0: got pc=%h id=%0d required pc=00500000 id=14", redirect_pc, redirect_issue_id);
        else n_pass++;
        sic_redir_id[0] = 4'd1;
        sic_redir_id[1] = 4'd14;
        tick();
        n_checks++;
        if (redirect_pc !== 32'h0060_0000 || redirect_issue_id !== 4'd14)
            $display("FAIL wrap_sic1: got pc=%h id=%0d required pc=00600000 id=14", redirect_pc, redirect_issue_id);
        else n_pass++;
        sic_redir_id[0] = 4'd3; sic_redir_pc[0] = 32'h0070_0000;
        sic_redir_id[1] = 4'd3; sic_redir_pc[1] = 32'h0080_0000;
        tick();
        n_checks++;
        if (redirect_pc !== 32'h0070_0000 || redirect_issue_id !== 4'd3)
            $display("FAIL tie_low_index: got pc=%h id=%0d required pc=00700000 id=3", redirect_pc, redirect_issue_id);
        else n_pass++;
        sic_redir_valid = 2'b00;
        tick();
    endtask

    task automatic test_async_reset();
        sic_req_instr = 2'b10;
        send(4'd10, 1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();                                   // offer on SIC1, held
        n_checks++; if (!sic_pkt[1].valid) $display("FAIL areset_pre: got %h required offer on sic1", sic_pkt); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sic_pkt !== '0 || in_ready !== 1'b1 || redirect_valid !== 1'b0 ||
            redirect_pc !== 32'h0 || redirect_issue_id !== 4'h0)
            $display("FAIL areset_outputs: got pkt=%h rdy=%b rv=%b pc=%h id=%h required all reset",
                     sic_pkt, in_ready, redirect_valid, redirect_pc, redirect_issue_id);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sic_req_instr = 2'b11;
        send(4'd11, 0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (!(sic_pkt[0].valid && sic_pkt[0].issue_id == 4'd11))
            $display("FAIL areset_first_sic0: got %h required id11 on sic0", sic_pkt);
        else n_pass++;
        sic_req_instr = 2'b10;
        tick();
        sic_req_instr = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_dispatch();
        test_round_robin_idle();
        test_full_fifo();
        test_redirect_flush();
        test_oldest_redirect();
        test_async_reset();
        tick();
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drained: got %0d outstanding required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
